// File: rtl/uart_rx_deser.sv
// uart_rx_deser
// Frame deserializer for the UART receive path. Collects data_len data bits
// (LSB- or MSB-first, selected at build time), checks an optional even/odd
// parity bit and the stop bit, and reports each frame with one-cycle strobes.
//
// State table
//   state  | meaning
//   IDLE   | waiting for frame_start; config latched on acceptance
//   DATA   | shifting in data bits, one per bit period
//   PARITY | sampling and checking the parity bit
//   STOP   | sampling the stop bit; strobes/P_DATA registered on exit
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   en           in   receiver enable; low aborts any frame and forces IDLE
//   frame_start  in   one-cycle pulse at the end of a valid start bit
//   sampled_bit  in   majority-sampled line value for the current bit
//   edge_count   in   oversampling edge counter within the current bit
//   prescale     in   oversampling ratio (8, 16 or 32)
//   data_len     in   data bits per frame, 5..DATA_WIDTH (else DATA_WIDTH)
//   par_en       in   parity bit present
//   par_typ      in   0 = even, 1 = odd
//   P_DATA       out  last good frame, right-aligned, unused upper bits 0
//   data_valid   out  one-cycle strobe: P_DATA updated with a good frame
//   par_err      out  one-cycle strobe: parity mismatch
//   stp_err      out  one-cycle strobe: stop bit sampled 0
//   busy         out  high in any state other than IDLE
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  frame_start,
  input  logic                  sampled_bit,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [3:0]            data_len,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [3:0]            bit_cnt, bit_cnt_nxt;
  logic [3:0]            cfg_len, cfg_len_nxt;
  logic                  cfg_par_en, cfg_par_en_nxt;
  logic                  cfg_par_typ, cfg_par_typ_nxt;
  logic                  par_fail, par_fail_nxt;
  logic [DATA_WIDTH-1:0] p_data_nxt;
  logic                  dv_nxt, pe_nxt, se_nxt;

  logic       bit_done;
  logic [3:0] wr_idx;
  logic       par_exp;
  logic       stop_fail;

  assign bit_done  = (edge_count == prescale - PRESCALE_W'(1));
  assign wr_idx    = (MSB_FIRST != 0) ? (cfg_len - 4'd1 - bit_cnt) : bit_cnt;
  // Shift register is cleared at frame start, so bits beyond cfg_len are 0
  // and do not disturb the reduction.
  assign par_exp   = (^shreg) ^ cfg_par_typ;
  assign stop_fail = !sampled_bit;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      cfg_len     <= '0;
      cfg_par_en  <= 1'b0;
      cfg_par_typ <= 1'b0;
      par_fail    <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      cfg_len     <= cfg_len_nxt;
      cfg_par_en  <= cfg_par_en_nxt;
      cfg_par_typ <= cfg_par_typ_nxt;
      par_fail    <= par_fail_nxt;
      P_DATA      <= p_data_nxt;
      data_valid  <= dv_nxt;
      par_err     <= pe_nxt;
      stp_err     <= se_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    shreg_nxt       = shreg;
    bit_cnt_nxt     = bit_cnt;
    cfg_len_nxt     = cfg_len;
    cfg_par_en_nxt  = cfg_par_en;
    cfg_par_typ_nxt = cfg_par_typ;
    par_fail_nxt    = par_fail;
    p_data_nxt      = P_DATA;
    dv_nxt          = 1'b0;
    pe_nxt          = 1'b0;
    se_nxt          = 1'b0;

    if (!en) begin
      // Partial frame state is left stale; it is cleared on the next start.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            state_nxt       = DATA;
            cfg_len_nxt     = (data_len < 4'd5 || data_len > MAX_LEN) ? MAX_LEN : data_len;
            cfg_par_en_nxt  = par_en;
            cfg_par_typ_nxt = par_typ;
            shreg_nxt       = '0;
            bit_cnt_nxt     = '0;
            par_fail_nxt    = 1'b0;
          end
        end
        DATA: begin
          if (bit_done) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (wr_idx == i[3:0]) shreg_nxt[i] = sampled_bit;
            end
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == cfg_len - 4'd1) state_nxt = cfg_par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (bit_done) begin
            if (sampled_bit != par_exp) par_fail_nxt = 1'b1;
            state_nxt = STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
            state_nxt = IDLE;
            pe_nxt    = par_fail;
            se_nxt    = stop_fail;
            if (!par_fail && !stop_fail) begin
              dv_nxt     = 1'b1;
              p_data_nxt = shreg;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       frame_start = 1'b0;
  logic       sampled_bit = 1'b1;
  logic [5:0] edge_count = '0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] data_len = 4'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;

  logic [7:0] p_l, p_m;
  logic       dv_l, pe_l, se_l, busy_l;
  logic       dv_m, pe_m, se_m, busy_m;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_rx_deser #(.DATA_WIDTH(8), .PRESCALE_W(6), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .sampled_bit(sampled_bit), .edge_count(edge_count), .prescale(prescale),
    .data_len(data_len), .par_en(par_en), .par_typ(par_typ),
    .P_DATA(p_l), .data_valid(dv_l), .par_err(pe_l), .stp_err(se_l), .busy(busy_l)
  );

  uart_rx_deser #(.DATA_WIDTH(8), .PRESCALE_W(6), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .sampled_bit(sampled_bit), .edge_count(edge_count), .prescale(prescale),
    .data_len(data_len), .par_en(par_en), .par_typ(par_typ),
    .P_DATA(p_m), .data_valid(dv_m), .par_err(pe_m), .stp_err(se_m), .busy(busy_m)
  );

  // Drive frame_start for one cycle; returns #1 after the accepting edge.
  task automatic pulse_start();
    edge_count  = '0;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Drive nbits bit periods, bits[0] first. Returns #1 after the last bit_done edge.
  task automatic send_bits(input logic [11:0] bits, input int nbits, input int ps);
    for (int b = 0; b < nbits; b++) begin
      for (int e = 0; e < ps; e++) begin
        sampled_bit = bits[b];
        edge_count  = e[5:0];
        @(posedge clk); #1;
      end
    end
    edge_count = '0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({p_l, dv_l, pe_l, se_l, busy_l} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_lsb: got %h required 000", {p_l, dv_l, pe_l, se_l, busy_l});
    end
    tests_run++;
    if ({p_m, dv_m, pe_m, se_m, busy_m} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_msb: got %h required 000", {p_m, dv_m, pe_m, se_m, busy_m});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8n1();
    prescale = 6'd8; data_len = 4'd8; par_en = 1'b0; par_typ = 1'b0;
    pulse_start();
    tests_run++;
    if (busy_l !== 1'b1) begin
      tests_failed++;
      $display("FAIL 8n1_busy_rise: got %b required 1", busy_l);
    end
    send_bits(12'h1A5, 9, 8);
    tests_run++;
    if ({dv_l, pe_l, se_l, busy_l} !== 4'b1000 || p_l !== 8'hA5) begin
      tests_failed++;
      $display("FAIL 8n1_a5: got dv/pe/se/busy=%b data=%h required 1000 a5", {dv_l, pe_l, se_l, busy_l}, p_l);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({dv_l, pe_l, se_l, busy_l} !== 4'b0000 || p_l !== 8'hA5) begin
      tests_failed++;
      $display("FAIL 8n1_after: got %b data=%h required 0000 a5", {dv_l, pe_l, se_l, busy_l}, p_l);
    end
  endtask

  task automatic test_parity_even();
    prescale = 6'd16; data_len = 4'd7; par_en = 1'b1; par_typ = 1'b0;
    pulse_start();
    send_bits(12'h135, 9, 16);
    tests_run++;
    if ({dv_l, pe_l, se_l} !== 3'b100 || p_l !== 8'h35) begin
      tests_failed++;
      $display("FAIL 7e1_good: got dv/pe/se=%b data=%h required 100 35", {dv_l, pe_l, se_l}, p_l);
    end
    tests_run++;
    if (dv_m !== 1'b1 || p_m !== 8'h56) begin
      tests_failed++;
      $display("FAIL 7e1_msb_order: got dv=%b data=%h required 1 56", dv_m, p_m);
    end
    @(posedge clk); #1;
    pulse_start();
    send_bits(12'h1B5, 9, 16);
    tests_run++;
    if ({dv_l, pe_l, se_l} !== 3'b010 || p_l !== 8'h35) begin
      tests_failed++;
      $display("FAIL 7e1_bad_parity: got dv/pe/se=%b data=%h required 010 35", {dv_l, pe_l, se_l}, p_l);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first_stop();
    prescale = 6'd8; data_len = 4'd5; par_en = 1'b1; par_typ = 1'b1;
    // bits 0,0,0,1,1 parity 1 stop 1
    pulse_start();
    send_bits(12'h078, 7, 8);
    tests_run++;
    if ({dv_m, pe_m, se_m} !== 3'b100 || p_m !== 8'h03) begin
      tests_failed++;
      $display("FAIL 5o1_msb_good: got dv/pe/se=%b data=%h required 100 03", {dv_m, pe_m, se_m}, p_m);
    end
    tests_run++;
    if (dv_l !== 1'b1 || p_l !== 8'h18) begin
      tests_failed++;
      $display("FAIL 5o1_lsb_good: got dv=%b data=%h required 1 18", dv_l, p_l);
    end
    @(posedge clk); #1;
    // bits 1,0,1,1,0 parity 0 stop 0
    pulse_start();
    send_bits(12'h00D, 7, 8);
    tests_run++;
    if ({dv_m, pe_m, se_m, busy_m} !== 4'b0010 || p_m !== 8'h03) begin
      tests_failed++;
      $display("FAIL 5o1_stop_err: got dv/pe/se/busy=%b data=%h required 0010 03", {dv_m, pe_m, se_m, busy_m}, p_m);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({se_m, busy_m} !== 2'b00) begin
      tests_failed++;
      $display("FAIL 5o1_idle: got se/busy=%b required 00", {se_m, busy_m});
    end
  endtask

  task automatic test_en_abort();
    logic seen;
    seen = 1'b0;
    prescale = 6'd8; data_len = 4'd8; par_en = 1'b0; par_typ = 1'b0;
    pulse_start();
    send_bits(12'h005, 3, 8);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      seen = seen | dv_l | pe_l | se_l;
    end
    tests_run++;
    if ({seen, busy_l, p_l} !== {2'b00, 8'h18}) begin
      tests_failed++;
      $display("FAIL abort_quiet: got strobe=%b busy=%b data=%h required 0 0 18", seen, busy_l, p_l);
    end
    en = 1'b1;
    send_bits(12'h1FF, 9, 8);
    tests_run++;
    if (seen !== 1'b0 || busy_l !== 1'b0 || dv_l !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_resume: got busy=%b dv=%b required 0 0", busy_l, dv_l);
    end
    @(posedge clk); #1;
    pulse_start();
    send_bits(12'h13C, 9, 8);
    tests_run++;
    if ({dv_l, pe_l, se_l} !== 3'b100 || p_l !== 8'h3C) begin
      tests_failed++;
      $display("FAIL abort_fresh_3c: got dv/pe/se=%b data=%h required 100 3c", {dv_l, pe_l, se_l}, p_l);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_parity();
    prescale = 6'd8; data_len = 4'd7; par_en = 1'b1; par_typ = 1'b0;
    pulse_start();
    send_bits(12'h035, 7, 8);
    for (int e = 0; e < 3; e++) begin
      sampled_bit = 1'b0;
      edge_count  = e[5:0];
      @(posedge clk); #1;
    end
    tests_run++;
    if (busy_l !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_busy: got %b required 1", busy_l);
    end
    #1;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({p_l, dv_l, pe_l, se_l, busy_l} !== 12'h000 || p_m !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_parity: got %h msb_data=%h required 000 00", {p_l, dv_l, pe_l, se_l, busy_l}, p_m);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    edge_count = '0;
    @(posedge clk); #1;
    data_len = 4'd8; par_en = 1'b0;
    pulse_start();
    send_bits(12'h1FF, 9, 8);
    tests_run++;
    if ({dv_l, pe_l, se_l} !== 3'b100 || p_l !== 8'hFF) begin
      tests_failed++;
      $display("FAIL rst_then_ff: got dv/pe/se=%b data=%h required 100 ff", {dv_l, pe_l, se_l}, p_l);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    prescale = 6'd8; data_len = 4'd8; par_en = 1'b0; par_typ = 1'b0;
    pulse_start();
    data_len = 4'd5;
    send_bits(12'h001, 4, 8);
    data_len = 4'd8;
    send_bits(12'h010, 5, 8);
    tests_run++;
    if ({dv_l, pe_l, se_l} !== 3'b100 || p_l !== 8'h01) begin
      tests_failed++;
      $display("FAIL b2b_first: got dv/pe/se=%b data=%h required 100 01", {dv_l, pe_l, se_l}, p_l);
    end
    pulse_start();
    tests_run++;
    if ({dv_l, busy_l} !== 2'b01 || p_l !== 8'h01) begin
      tests_failed++;
      $display("FAIL b2b_accept: got dv/busy=%b data=%h required 01 01", {dv_l, busy_l}, p_l);
    end
    send_bits(12'h180, 9, 8);
    tests_run++;
    if ({dv_l, pe_l, se_l} !== 3'b100 || p_l !== 8'h80) begin
      tests_failed++;
      $display("FAIL b2b_second: got dv/pe/se=%b data=%h required 100 80", {dv_l, pe_l, se_l}, p_l);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({dv_l, busy_l} !== 2'b00) begin
      tests_failed++;
      $display("FAIL b2b_end: got dv/busy=%b required 00", {dv_l, busy_l});
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity_even();
    test_msb_first_stop();
    test_en_abort();
    test_reset_mid_parity();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
